// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU command-issue stage: op codes, command entry, FSM states.
package alu_issue_pkg;

  localparam int W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Codes above ROR have no ALU function behind them.
  function automatic logic op_unsupported(input logic [2:0] op);
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/alu_issue_cmd_fifo.sv
// Command FIFO: head visible the cycle after push; push refused when full (no pop fall-through).
// Pointers wrap naturally; a separate occupancy counter carries the extra bit for full/empty.
module cmd_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  cmd_t        push_dat_i,
  input  logic        pop_i,
  output cmd_t        head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage ahead of the 8-bit ALU: result valid one edge after a command reaches the FIFO head.
// A held result (res_valid && !res_ready) blocks issue; the FIFO absorbs up to DEPTH commands.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  input  logic          cmd_use_acc,
  input  logic          acc_clr,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_sel,
  input  logic [W-1:0]  alu_r,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_zero,
  output logic          res_err,
  output logic [W-1:0]  acc_out,
  output logic [LW-1:0] level
);

  state_t       state_q;
  logic         res_valid_q, res_zero_q, res_err_q;
  logic [W-1:0] res_data_q, acc_q, acc_eff;
  cmd_t         head, push_dat;
  logic         full, empty, push, issue_en, issue;

  assign push_dat = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
  assign push     = cmd_valid && !full;
  assign cmd_ready = !full;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (issue),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

  // Slot is free when empty, or when the held result leaves this edge.
  assign issue_en = (state_q == ST_IDLE) || res_ready;
  assign issue    = issue_en && !empty;

  // A clear in the same cycle must already be visible to a use_acc head.
  assign acc_eff = acc_clr ? '0 : acc_q;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = head.use_acc ? acc_eff : head.a;
      alu_b   = head.b;
      alu_sel = head.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (acc_clr)    acc_q <= '0;
      else if (issue) acc_q <= alu_r;

      if (issue) begin
        res_data_q  <= alu_r;
        res_zero_q  <= (alu_r == '0);
        res_err_q   <= op_unsupported(head.op);
        res_valid_q <= 1'b1;
        state_q     <= ST_RUN;
      end else begin
        case (state_q)
          ST_RUN, ST_STALL: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              state_q     <= ST_STALL;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU and an in-order result scoreboard.
module tb_alu_issue;
  import alu_issue_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       z;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_acc, acc_clr;
  logic [2:0] cmd_op, alu_sel;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_r;
  logic       res_valid, res_ready, res_zero, res_err;
  logic [7:0] res_data, acc_out;
  logic [2:0] level;

  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];
  logic [7:0] m_acc = 8'h00;

  alu_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_err(res_err), .acc_out(acc_out), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return {a[6:0], a[7]};
      3'b101:  return {a[0], a[7:1]};
      default: return 8'h00;
    endcase
  endfunction

  assign alu_r = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any handshake at the negedge, then advance to just past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (res_valid && res_ready) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(e.d));
        chk("res_zero", 32'(res_zero), 32'(e.z));
        chk("res_err",  32'(res_err),  32'(e.e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
    logic [7:0] r;
    logic       done;
    done        = 1'b0;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 32'(done), 32'd1);
    r     = alu_f(op, ua ? m_acc : a, b);
    m_acc = r;
    sb.push_back('{d: r, z: (r == 8'h00), e: (op[2:1] == 2'b11)});
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_zero",  32'(res_zero),  32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);
    chk("rst_acc",       32'(acc_out),   32'd0);
    chk("rst_alu_drive", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD and its latency
    res_ready = 1'b1;
    push_cmd(OP_ADD, 8'h05, 8'h03, 1'b0);
    chk("add_not_yet_valid", 32'(res_valid), 32'd0);
    tick();
    chk("add_valid",    32'(res_valid), 32'd1);
    chk("add_data",     32'(res_data),  32'h08);
    chk("add_zero",     32'(res_zero),  32'd0);
    chk("add_acc",      32'(acc_out),   32'h08);
    tick();
    chk("add_drained",  32'(res_valid), 32'd0);

    // Chained accumulate: 30, 35, 0
    push_cmd(OP_ADD, 8'd10, 8'd20, 1'b0);
    push_cmd(OP_ADD, 8'hEE, 8'd5,  1'b1);
    push_cmd(OP_SUB, 8'hEE, 8'd35, 1'b1);
    repeat (3) tick();
    chk("chain_acc", 32'(acc_out), 32'd0);

    // Unsupported op and rotates
    push_cmd(3'b110, 8'h55, 8'h22, 1'b0);
    push_cmd(OP_ROL, 8'h81, 8'h00, 1'b0);
    push_cmd(OP_ROR, 8'h81, 8'h00, 1'b0);
    push_cmd(3'b111, 8'h01, 8'h01, 1'b0);
    repeat (4) tick();
    chk("rot_drained", 32'(res_valid), 32'd0);

    // Backpressure: one result held, FIFO fills to DEPTH
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_cmd(OP_ADD, 8'(i * 16), 8'h01, 1'b0);
    chk("bp_level",     32'(level),     32'd4);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    cmd_valid = 1'b1; cmd_op = OP_OR; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_use_acc = 1'b0;
    repeat (3) tick();
    cmd_valid = 1'b0;
    chk("bp_level_held", 32'(level),    32'd4);
    chk("bp_data_held",  32'(res_data), 32'h11);
    res_ready = 1'b1;
    repeat (5) tick();
    chk("bp_all_out",    32'(sb.size()), 32'd0);
    chk("bp_valid_low",  32'(res_valid), 32'd0);

    // acc_clr collides with capture of 0x44; following use_acc OR sees zero
    push_cmd(OP_ADD, 8'h40, 8'h04, 1'b0);
    acc_clr = 1'b1;
    m_acc   = 8'h00;
    push_cmd(OP_OR, 8'hAA, 8'h0F, 1'b1);
    acc_clr = 1'b0;
    chk("clr_res_data", 32'(res_data), 32'h44);
    chk("clr_acc",      32'(acc_out),  32'h00);
    repeat (2) tick();
    chk("clr_or_acc",   32'(acc_out),  32'h0F);

    // Asynchronous reset mid-stream
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(OP_ADD, 8'h21, 8'(i), 1'b0);
    chk("mid_level", 32'(level),     32'd3);
    chk("mid_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_level", 32'(level),     32'd0);
    chk("arst_acc",   32'(acc_out),   32'd0);
    sb.delete();
    m_acc = 8'h00;
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    repeat (4) tick();
    chk("post_rst_idle", 32'(res_valid), 32'd0);
    push_cmd(OP_AND, 8'hF0, 8'h3C, 1'b0);
    repeat (2) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
